// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing types and constants for the VGA timing generator.
//   vga_axis_t     : one axis of timing (display / front porch / sync / back porch)
//   VGA640_H/V     : 640x480@60 axis timings
//   VGA640_CLK_DIV : system clocks per pixel for a 100 MHz board clock
//   axis_total()   : pixels (or lines) in a full axis period
//   axis_valid()   : true when every segment of an axis is non-empty
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    int unsigned disp;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  localparam vga_axis_t VGA640_H = '{disp: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_axis_t VGA480_V = '{disp: 480, fp: 10, sync: 2,  bp: 33};
  localparam int unsigned VGA640_CLK_DIV = 4;

  function automatic int unsigned axis_total(vga_axis_t a);
    return a.disp + a.fp + a.sync + a.bp;
  endfunction

  function automatic bit axis_valid(vga_axis_t a);
    return (a.disp != 0) && (a.fp != 0) && (a.sync != 0) && (a.bp != 0);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical). Counts position 0..TOT-1 on each
// step and decodes the active region and sync pulse from the NEXT position so
// that decoded outputs line up with the position register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous return to position 0 (priority over step)
//   step        : advance one position this clock
//   pos         : registered position
//   wrap        : combinational, high on the step that takes pos from TOT-1 to 0
//   active_nxt  : combinational, next position lies in the display region
//   sync        : registered sync level, active level given by POL
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned DISP = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48,
  parameter bit          POL  = 1'b0,
  localparam vga_axis_t   CFG = '{disp: DISP, fp: FP, sync: SYNC, bp: BP},
  localparam int unsigned TOT = axis_total(CFG),
  localparam int unsigned PW  = $clog2(TOT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  output logic [PW-1:0] pos,
  output logic          wrap,
  output logic          active_nxt,
  output logic          sync
);

  if (!axis_valid(CFG)) begin : g_bad_axis
    $error("vga_axis_counter: display, porch and sync widths must all be non-zero");
  end

  localparam logic [PW-1:0] LAST       = PW'(TOT - 1);
  localparam logic [PW-1:0] DISP_END   = PW'(DISP);
  localparam logic [PW-1:0] SYNC_START = PW'(DISP + FP);
  localparam logic [PW-1:0] SYNC_END   = PW'(DISP + FP + SYNC - 1);

  logic [PW-1:0] pos_q, pos_d;
  logic          sync_q, sync_d;

  always_comb begin
    pos_d      = pos_q;
    wrap       = 1'b0;
    active_nxt = 1'b0;
    sync_d     = ~POL;
    if (clear) begin
      pos_d = '0;
    end else begin
      if (step) begin
        wrap  = (pos_q == LAST);
        pos_d = wrap ? '0 : pos_q + 1'b1;
      end
      // Decode from the next position so the registered sync and the
      // caller's registered active flag change on the same edge as pos.
      active_nxt = (pos_d < DISP_END);
      if ((pos_d >= SYNC_START) && (pos_d <= SYNC_END)) begin
        sync_d = POL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      sync_q <= ~POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos  = pos_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator in a single clock domain. A divider makes
// a one-clock pixel tick; two axis counters produce x/y with their blanking and
// sync decodes; a frame counter tracks completed frames. Every output is a flop.
// Ports:
//   clk_100MHz   : system clock
//   reset_n      : asynchronous active-low reset
//   en           : timing enable, 0 holds the restart state (frame_cnt kept)
//   p_tick       : one-clock pixel enable every CLK_DIV clocks
//   x, y         : pixel position
//   video_on     : position lies in the active display area
//   hsync, vsync : sync outputs, active level per HS_POL / VS_POL
//   line_start   : one-clock pulse when x wraps to 0
//   frame_start  : one-clock pulse when (x,y) wraps to (0,0)
//   frame_cnt    : completed frames, wraps
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA640_CLK_DIV,
  parameter int unsigned H_DISP  = VGA640_H.disp,
  parameter int unsigned H_FP    = VGA640_H.fp,
  parameter int unsigned H_SYNC  = VGA640_H.sync,
  parameter int unsigned H_BP    = VGA640_H.bp,
  parameter int unsigned V_DISP  = VGA480_V.disp,
  parameter int unsigned V_FP    = VGA480_V.fp,
  parameter int unsigned V_SYNC  = VGA480_V.sync,
  parameter int unsigned V_BP    = VGA480_V.bp,
  parameter int          HS_POL  = 0,
  parameter int          VS_POL  = 0,
  parameter int unsigned FC_W    = 8,
  localparam vga_axis_t   H_CFG = '{disp: H_DISP, fp: H_FP, sync: H_SYNC, bp: H_BP},
  localparam vga_axis_t   V_CFG = '{disp: V_DISP, fp: V_FP, sync: V_SYNC, bp: V_BP},
  localparam int unsigned H_TOT = axis_total(H_CFG),
  localparam int unsigned V_TOT = axis_total(V_CFG),
  localparam int unsigned XW    = $clog2(H_TOT),
  localparam int unsigned YW    = $clog2(V_TOT)
) (
  input  logic            clk_100MHz,
  input  logic            reset_n,
  input  logic            en,
  output logic            p_tick,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic            video_on,
  output logic            hsync,
  output logic            vsync,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  // A one-state divider still needs a one-bit counter to stay legal.
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            p_tick_q, p_tick_d;
  logic            video_on_q, video_on_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  logic h_wrap, v_wrap;
  logic h_active_nxt, v_active_nxt;

  // The line counter advances on the registered tick, so x moves one clock
  // after p_tick is seen high; the frame counter steps on each line wrap.
  vga_axis_counter #(
    .DISP (H_DISP),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .POL  (HS_POL != 0)
  ) u_h_axis (
    .clk        (clk_100MHz),
    .rst_n      (reset_n),
    .clear      (~en),
    .step       (p_tick_q),
    .pos        (x),
    .wrap       (h_wrap),
    .active_nxt (h_active_nxt),
    .sync       (hsync)
  );

  vga_axis_counter #(
    .DISP (V_DISP),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .POL  (VS_POL != 0)
  ) u_v_axis (
    .clk        (clk_100MHz),
    .rst_n      (reset_n),
    .clear      (~en),
    .step       (h_wrap),
    .pos        (y),
    .wrap       (v_wrap),
    .active_nxt (v_active_nxt),
    .sync       (vsync)
  );

  always_comb begin
    div_cnt_d     = '0;
    p_tick_d      = 1'b0;
    video_on_d    = h_active_nxt && v_active_nxt;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_cnt_d   = frame_cnt_q;
    if (en) begin
      p_tick_d  = (div_cnt_q == DIV_LAST);
      div_cnt_d = p_tick_d ? '0 : div_cnt_q + 1'b1;
    end
    // v_wrap already implies a line wrap, so it marks a completed frame.
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      p_tick_q      <= 1'b0;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      p_tick_q      <= p_tick_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share one clock: dutA uses the 640x480 defaults (CLK_DIV 4),
// dutB a tiny 14x8 timing with CLK_DIV 1, active-high syncs and a 2-bit frame
// counter. Expected values come from closed-form expressions of the number of
// clock edges since timing was (re)enabled.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aResetN, aEn;
  logic       aTick, aVideo, aHs, aVs, aLine, aFrame;
  logic [9:0] aX, aY;
  logic [7:0] aFc;

  logic       bResetN, bEn;
  logic       bTick, bVideo, bHs, bVs, bLine, bFrame;
  logic [3:0] bX;
  logic [2:0] bY;
  logic [1:0] bFc;

  int vectorCount = 0;
  int missCount   = 0;
  int stepIdx     = 0;

  vga_timing_gen dutA (
    .clk_100MHz  (clk),
    .reset_n     (aResetN),
    .en          (aEn),
    .p_tick      (aTick),
    .x           (aX),
    .y           (aY),
    .video_on    (aVideo),
    .hsync       (aHs),
    .vsync       (aVs),
    .line_start  (aLine),
    .frame_start (aFrame),
    .frame_cnt   (aFc)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_DISP  (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_DISP  (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL  (1), .VS_POL (1),
    .FC_W    (2)
  ) dutB (
    .clk_100MHz  (clk),
    .reset_n     (bResetN),
    .en          (bEn),
    .p_tick      (bTick),
    .x           (bX),
    .y           (bY),
    .video_on    (bVideo),
    .hsync       (bHs),
    .vsync       (bVs),
    .line_start  (bLine),
    .frame_start (bFrame),
    .frame_cnt   (bFc)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s (step %0d): observed %0d, expected %0d", tag, stepIdx, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic resetN, input logic enable);
    if (toB) begin
      bResetN = resetN;
      bEn     = enable;
    end else begin
      aResetN = resetN;
      aEn     = enable;
    end
  endtask

  // Outputs of dutA while held in reset or in the disabled restart state.
  task automatic checkIdleA(input string ph, input int fc);
    checkOutput({ph, ".p_tick"},      aTick,  0);
    checkOutput({ph, ".x"},           aX,     0);
    checkOutput({ph, ".y"},           aY,     0);
    checkOutput({ph, ".video_on"},    aVideo, 0);
    checkOutput({ph, ".hsync"},       aHs,    1);
    checkOutput({ph, ".vsync"},       aVs,    1);
    checkOutput({ph, ".line_start"},  aLine,  0);
    checkOutput({ph, ".frame_start"}, aFrame, 0);
    checkOutput({ph, ".frame_cnt"},   aFc,    fc);
  endtask

  task automatic checkIdleB(input string ph, input int fc);
    checkOutput({ph, ".p_tick"},      bTick,  0);
    checkOutput({ph, ".x"},           bX,     0);
    checkOutput({ph, ".y"},           bY,     0);
    checkOutput({ph, ".video_on"},    bVideo, 0);
    checkOutput({ph, ".hsync"},       bHs,    0);
    checkOutput({ph, ".vsync"},       bVs,    0);
    checkOutput({ph, ".line_start"},  bLine,  0);
    checkOutput({ph, ".frame_start"}, bFrame, 0);
    checkOutput({ph, ".frame_cnt"},   bFc,    fc);
  endtask

  // k = clock edges since the first edge with reset released and en high.
  // With a divide of 4 the tick lands on edges 4, 8, ... and x follows one
  // edge later, so after edge k the pixel index is (k-1)/4.
  task automatic checkA(input int k);
    int n, ex, ey;
    n  = (k - 1) / 4;
    ex = n % 800;
    ey = n / 800;
    stepIdx = k;
    checkOutput("A.p_tick",      aTick,  (k % 4 == 0) ? 1 : 0);
    checkOutput("A.x",           aX,     ex);
    checkOutput("A.y",           aY,     ey);
    checkOutput("A.video_on",    aVideo, (ex < 640 && ey < 480) ? 1 : 0);
    checkOutput("A.hsync",       aHs,    (ex >= 656 && ex <= 751) ? 0 : 1);
    checkOutput("A.vsync",       aVs,    (ey >= 490 && ey <= 491) ? 0 : 1);
    checkOutput("A.line_start",  aLine,  (k % 4 == 1 && n > 0 && ex == 0) ? 1 : 0);
    checkOutput("A.frame_start", aFrame, 0);
    checkOutput("A.frame_cnt",   aFc,    0);
  endtask

  // With CLK_DIV 1 the tick is high from edge 1 on and the pixel index is k-1.
  // 14 pixels per line, 8 lines per frame, 112 clocks per frame.
  task automatic checkB(input int k, input int fcBase);
    int n, ex, ey;
    n  = k - 1;
    ex = n % 14;
    ey = (n / 14) % 8;
    stepIdx = k;
    checkOutput("B.p_tick",      bTick,  1);
    checkOutput("B.x",           bX,     ex);
    checkOutput("B.y",           bY,     ey);
    checkOutput("B.video_on",    bVideo, (ex < 8 && ey < 4) ? 1 : 0);
    checkOutput("B.hsync",       bHs,    (ex >= 10 && ex <= 12) ? 1 : 0);
    checkOutput("B.vsync",       bVs,    (ey >= 5 && ey <= 6) ? 1 : 0);
    checkOutput("B.line_start",  bLine,  (n > 0 && ex == 0) ? 1 : 0);
    checkOutput("B.frame_start", bFrame, (n > 0 && n % 112 == 0) ? 1 : 0);
    checkOutput("B.frame_cnt",   bFc,    (fcBase + n / 112) % 4);
  endtask

  task automatic runA(input int last);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      checkA(k);
    end
  endtask

  task automatic runB(input int last, input int fcBase);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      checkB(k, fcBase);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    stepIdx = 0;
    checkIdleA("A.reset", 0);
    checkIdleB("B.reset", 0);

    // Defaults: two full lines plus a little of the third, covering first
    // tick latency, x wrap at 799, the hsync window and line_start spacing.
    applyStimulus(1'b0, 1'b1, 1'b1);
    runA(6600);

    // Drop en on an edge where a tick is pending; the restart state wins.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      stepIdx = i;
      checkIdleA("A.en_off", 0);
    end

    // Restart: fresh frame, first tick CLK_DIV clocks later, no start pulse.
    applyStimulus(1'b0, 1'b1, 1'b1);
    runA(2700);

    // Reset mid-line while p_tick is high and hsync active: outputs must fall
    // back with no clock edge in between.
    #2;
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    stepIdx = 0;
    checkIdleA("A.async_rst", 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    runA(20);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Small timing: five full frames, frame_cnt 1,2,3,0,1 with frame_start.
    applyStimulus(1'b1, 1'b1, 1'b1);
    runB(565, 0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      stepIdx = i;
      checkIdleB("B.en_off", 1);
    end

    applyStimulus(1'b1, 1'b1, 1'b1);
    runB(120, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
